instr_prefetch_queue: RTL and testbench
=======================================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter WIDTH, default 16, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, DEPTH >= 2.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; reset = 0 clears all state immediately, independent of clk.
REQ-005 Port ld  input  1  push request; write D_in into the queue this cycle.
REQ-006 Port D_in  input  WIDTH  instruction word from external memory.
REQ-007 Port adv  input  1  pop request; the decoder has consumed the head entry.
REQ-008 Port flush  input  1  discard all queued entries (branch or jump taken).
REQ-009 Port IR_out  output  WIDTH  head entry (first-word-fall-through); all zeros when empty.
REQ-010 Port IR_valid  output  1  high when IR_out holds a valid entry (count != 0).
REQ-011 Port full  output  1  high when count == DEPTH.
REQ-012 Port empty  output  1  high when count == 0.
REQ-013 Port count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-014 Port ovf  output  1  sticky overflow flag: a push was dropped.

Function
REQ-015 Storage SHALL be a circular buffer with write pointer, read pointer and count; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 IR_out SHALL be driven from the entry at the read pointer, with no added latency; a word pushed into an empty queue SHALL appear on IR_out the cycle after the push edge.
REQ-017 Effective push = ld and (not full, or adv while full); effective pop = adv and not empty.
REQ-018 Push only: store D_in at write pointer, increment write pointer, count + 1.
REQ-019 Pop only: increment read pointer, count - 1.
REQ-020 Push and pop in the same cycle: both pointers advance, count unchanged; this SHALL hold when full (slot freed and refilled same edge).
REQ-021 ld while empty with adv high: adv SHALL be ignored; D_in stored; count becomes 1.
REQ-022 adv while empty with no ld: no state change; no underflow indication.
REQ-023 ld while full without adv: D_in SHALL be dropped, queue unchanged, ovf set to 1.
REQ-024 ovf SHALL remain 1 until flush or reset.
REQ-025 flush SHALL override adv: all entries discarded, both pointers set to 0, ovf cleared.
REQ-026 flush with ld in the same cycle: the queue SHALL contain only D_in at the next edge (count = 1), so the branch-target word is not lost.
REQ-027 flush without ld: count = 0 after the edge.
REQ-028 full, empty, IR_valid and ovf SHALL be derived from registered state only, never from the current-cycle inputs.
REQ-029 Storage contents outside the valid region SHALL never reach IR_out.

Reset
REQ-030 While reset = 0: pointers = 0, count = 0, ovf = 0, empty = 1, full = 0, IR_valid = 0, IR_out = 0.
REQ-031 Storage array contents need not be cleared on reset.
REQ-032 Deasserting reset mid-operation SHALL leave the queue empty; the first edge after release SHALL behave as a normal cycle.

Verification
REQ-033 Reset, then push 16'h1A2B, 16'h3C4D -> count = 2, IR_out = 16'h1A2B; one adv -> IR_out = 16'h3C4D, count = 1.
REQ-034 Fill DEPTH = 4 with 16'h0001..16'h0004, then ld 16'h0005 without adv -> full = 1, count = 4, ovf = 1, IR_out = 16'h0001; drain gives 0001..0004 in order.
REQ-035 Full queue, ld 16'hBEEF with adv -> count stays 4, IR_out = 16'h0002; draining ends with 16'hBEEF; ovf not set.
REQ-036 Three entries queued, flush with ld 16'h8000 and adv -> count = 1, IR_out = 16'h8000, ovf = 0.
REQ-037 Push/pop 10 words through DEPTH = 4 (pointer wrap) -> output order matches input order; adv on empty -> no change.
REQ-038 Assert reset asynchronously between edges with count = 3 -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: a circular FIFO between external instruction memory
// and the decoder, with first-word-fall-through output, flush for taken branches,
// and a sticky overflow flag for dropped pushes.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   ld       - push request, D_in is written this cycle
//   D_in     - instruction word from memory
//   adv      - pop request, decoder consumed the head entry
//   flush    - discard all entries (a concurrent ld keeps only D_in)
//   IR_out   - head entry, zero when empty
//   IR_valid - head entry is valid
//   full     - count == DEPTH
//   empty    - count == 0
//   count    - number of valid entries, 0..DEPTH
//   ovf      - sticky: a push was dropped because the queue was full
module instr_prefetch_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld,
  input  logic [WIDTH-1:0]         D_in,
  input  logic                     adv,
  input  logic                     flush,
  output logic [WIDTH-1:0]         IR_out,
  output logic                     IR_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             full_s, empty_s;
  logic             push_en, pop_en;
  logic             mem_we;
  logic [PtrW-1:0]  mem_waddr;

  // Status comes from registered state only.
  assign full_s  = (count_q == CntW'(DEPTH));
  assign empty_s = (count_q == '0);

  // When full, a simultaneous pop frees the slot this push refills.
  assign push_en = ld && (!full_s || adv);
  assign pop_en  = adv && !empty_s;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;

    if (flush) begin
      // Flush wins over adv; a concurrent ld becomes the sole entry (branch target).
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      if (ld) begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        wr_ptr_d  = PtrW'(1);
        count_d   = CntW'(1);
      end else begin
        wr_ptr_d = '0;
        count_d  = '0;
      end
    end else begin
      if (push_en) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (ld && full_s && !adv) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the empty gating on IR_out hides stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= D_in;
    end
  end

  assign IR_out   = empty_s ? '0 : mem_q[rd_ptr_q];
  assign IR_valid = !empty_s;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: a queue-based reference model,
// a per-cycle compare process on the falling edge, directed scenarios with
// literal expectations, and a randomized run.
module tb_instr_prefetch_queue;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             ld;
  logic [WIDTH-1:0] D_in;
  logic             adv;
  logic             flush;
  logic [WIDTH-1:0] IR_out;
  logic             IR_valid;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             ovf;

  instr_prefetch_queue #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ld      (ld),
    .D_in    (D_in),
    .adv     (adv),
    .flush   (flush),
    .IR_out  (IR_out),
    .IR_valid(IR_valid),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Reference model: the queue contents in order, plus the sticky flag.
  logic [WIDTH-1:0] mq[$];
  bit               movf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit l, input bit a, input bit f, input logic [WIDTH-1:0] d);
    bit was_full;
    bit do_pop;
    bit do_push;
    if (f) begin
      mq.delete();
      if (l) mq.push_back(d);
      movf = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = a && (mq.size() != 0);
      do_push  = l && (!was_full || a);
      if (l && was_full && !a) movf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
  endtask

  // Drive one cycle's inputs, advance through the rising edge, update the model.
  task automatic step(input bit l, input bit a, input bit f, input logic [WIDTH-1:0] d);
    ld    = l;
    adv   = a;
    flush = f;
    D_in  = d;
    @(posedge clk);
    model_edge(l, a, f, d);
    #1;
    ld    = 1'b0;
    adv   = 1'b0;
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("count",    32'(count),    32'(mq.size()));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("full",     32'(full),     32'(mq.size() == DEPTH));
      check("IR_valid", 32'(IR_valid), 32'(mq.size() != 0));
      check("ovf",      32'(ovf),      32'(movf));
      check("IR_out",   32'(IR_out),   (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    end
  end

  initial begin
    ld = 1'b0; adv = 1'b0; flush = 1'b0; D_in = '0;
    movf = 1'b0;
    reset = 1'b0;
    #3;
    check("rst_count",  32'(count),    32'h0);
    check("rst_empty",  32'(empty),    32'h1);
    check("rst_full",   32'(full),     32'h0);
    check("rst_valid",  32'(IR_valid), 32'h0);
    check("rst_ovf",    32'(ovf),      32'h0);
    check("rst_IR_out", 32'(IR_out),   32'h0);
    #9 reset = 1'b1;
    check_en = 1'b1;
    @(posedge clk); #1;

    // Two pushes, one pop.
    step(1, 0, 0, 16'h1A2B);
    step(1, 0, 0, 16'h3C4D);
    check("two_push_count", 32'(count),  32'd2);
    check("two_push_head",  32'(IR_out), 32'h1A2B);
    step(0, 1, 0, 16'h0);
    check("pop_head",  32'(IR_out), 32'h3C4D);
    check("pop_count", 32'(count),  32'd1);
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    check("adv_empty_count", 32'(count), 32'd0);
    check("adv_empty_ovf",   32'(ovf),   32'd0);
    // ld with adv on empty: adv ignored.
    step(1, 1, 0, 16'h7777);
    check("ld_adv_empty_count", 32'(count),  32'd1);
    check("ld_adv_empty_head",  32'(IR_out), 32'h7777);
    step(0, 1, 0, 16'h0);

    // Fill then overflow.
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'(i));
    step(1, 0, 0, 16'h0005);
    check("ovf_full",  32'(full),   32'd1);
    check("ovf_count", 32'(count),  32'd4);
    check("ovf_flag",  32'(ovf),    32'd1);
    check("ovf_head",  32'(IR_out), 32'h0001);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain", 32'(IR_out), 32'(i));
      step(0, 1, 0, 16'h0);
    end
    check("ovf_sticky", 32'(ovf), 32'd1);
    step(0, 0, 1, 16'h0);
    check("flush_clr_ovf",   32'(ovf),   32'd0);
    check("flush_clr_count", 32'(count), 32'd0);

    // Push and pop while full.
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'(i));
    step(1, 1, 0, 16'hBEEF);
    check("fullpp_count", 32'(count),  32'd4);
    check("fullpp_head",  32'(IR_out), 32'h0002);
    check("fullpp_ovf",   32'(ovf),    32'd0);
    check("fullpp_d2",    32'(IR_out), 32'h0002); step(0, 1, 0, 16'h0);
    check("fullpp_d3",    32'(IR_out), 32'h0003); step(0, 1, 0, 16'h0);
    check("fullpp_d4",    32'(IR_out), 32'h0004); step(0, 1, 0, 16'h0);
    check("fullpp_dBEEF", 32'(IR_out), 32'hBEEF); step(0, 1, 0, 16'h0);
    check("fullpp_empty", 32'(empty),  32'd1);

    // Flush with ld and adv.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0A00 + 16'(i));
    step(1, 1, 1, 16'h8000);
    check("flush_ld_count", 32'(count),  32'd1);
    check("flush_ld_head",  32'(IR_out), 32'h8000);
    check("flush_ld_ovf",   32'(ovf),    32'd0);
    step(0, 1, 0, 16'h0);

    // Ten words through the queue, wrapping both pointers.
    step(1, 0, 0, 16'h0100);
    step(1, 0, 0, 16'h0101);
    for (int k = 0; k < 8; k++) begin
      check("wrap_order", 32'(IR_out), 32'h0100 + 32'(k));
      step(1, 1, 0, 16'h0102 + 16'(k));
    end
    for (int k = 8; k < 10; k++) begin
      check("wrap_order", 32'(IR_out), 32'h0100 + 32'(k));
      step(0, 1, 0, 16'h0);
    end
    step(0, 1, 0, 16'h0);
    check("wrap_adv_empty", 32'(count), 32'd0);

    // Asynchronous reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0C00 + 16'(i));
    #1 reset = 1'b0;
    mq.delete();
    movf = 1'b0;
    #1;
    check("async_count", 32'(count),    32'd0);
    check("async_empty", 32'(empty),    32'd1);
    check("async_valid", 32'(IR_valid), 32'd0);
    check("async_IR",    32'(IR_out),   32'h0);
    #1 reset = 1'b1;
    step(1, 0, 0, 16'hABCD);
    check("post_rst_count", 32'(count),  32'd1);
    check("post_rst_head",  32'(IR_out), 32'hABCD);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99) < 60, $urandom_range(99) < 50, $urandom_range(99) < 4,
           16'($urandom));
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
